bridge_traffic_counter: RTL

BRIDGE_TRAFFIC_COUNTER -- requirements
Module: bridge_traffic_counter

---
 rtl/bridge_traffic_counter.sv | 69 ++++++
 1 files changed

// File: rtl/bridge_traffic_counter.sv
// bridge_traffic_counter: bridge deck occupancy counter with a drain/raise permission FSM.
// Sensor inputs are edge detected; every output is registered.
module bridge_traffic_counter #(
   parameter int CNT_W    = 4,
   parameter int CAPACITY = 10
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CarIn,
   input  logic             CarOut,
   input  logic             RaiseReq,
   input  logic             ErrClr,
   output logic [CNT_W-1:0] Count,
   output logic             ExistCar,
   output logic             Full,
   output logic             EntryAllowed,
   output logic             BridgeUp,
   output logic             Error
);
   typedef enum logic [1:0] {OPEN, DRAIN, RAISED} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
   state_t           state, state_nxt;
   logic             prev_in, prev_out, ev_in, ev_out, inc, dec, sat_hi, sat_lo;
   logic             err_set, entry_nxt, up_nxt;
   logic [CNT_W-1:0] count_nxt;
   always_comb begin
      ev_in     = CarIn & ~prev_in;
      ev_out    = CarOut & ~prev_out;
      inc       = ev_in & ~ev_out;
      dec       = ev_out & ~ev_in;
      sat_hi    = inc && Count == CNT_MAX;
      sat_lo    = dec && Count == '0;
      count_nxt = (inc && !sat_hi) ? Count + 1'b1 : (dec && !sat_lo) ? Count - 1'b1 : Count;
      // a car entering a raised deck is still counted but is always an error
      err_set   = sat_hi | sat_lo | (ev_in && state == RAISED);
   end
   always_comb
      state_nxt = state == OPEN   ? (RaiseReq ? DRAIN : OPEN)
                : state == DRAIN  ? (!RaiseReq ? OPEN : count_nxt == '0 ? RAISED : DRAIN)
                : state == RAISED ? (ev_in ? DRAIN : !RaiseReq ? OPEN : RAISED)
                : OPEN;
   always_comb begin
      entry_nxt = state_nxt == OPEN && count_nxt < CAP;
      up_nxt    = state_nxt == RAISED;
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         state        <= OPEN;
         prev_in      <= 1'b0;
         prev_out     <= 1'b0;
         Count        <= '0;
         ExistCar     <= 1'b0;
         Full         <= 1'b0;
         EntryAllowed <= 1'b1;
         BridgeUp     <= 1'b0;
         Error        <= 1'b0;
      end else begin
         state        <= state_nxt;
         prev_in      <= CarIn;
         prev_out     <= CarOut;
         Count        <= count_nxt;
         ExistCar     <= count_nxt != '0;
         Full         <= count_nxt >= CAP;
         EntryAllowed <= entry_nxt;
         BridgeUp     <= up_nxt;
         Error        <= err_set ? 1'b1 : ErrClr ? 1'b0 : Error;
      end
endmodule
